// File: rtl/dmem_pkg.sv
// Shared types and sizing helpers for the D-cache memory responder.
package dmem_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
        logic            is_write;
    } dmem_req_t;

    // Latency counter only has to hold LATENCY-1; keep at least one bit.
    function automatic int cnt_width(input int latency);
        return (latency > 2) ? $clog2(latency) : 1;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Miss/writeback handshake between the D-cache (master) and memory responder (slave).
interface dmem_responder_if;

    logic [dmem_pkg::XLEN-1:0] mem_addr;
    logic [dmem_pkg::XLEN-1:0] mem_write_data;
    logic                      mem_write;
    logic                      mem_request;
    logic                      mem_ready;
    logic [dmem_pkg::XLEN-1:0] mem_data;
    logic                      busy;

    modport master (
        output mem_addr, mem_write_data, mem_write, mem_request,
        input  mem_ready, mem_data, busy
    );

    modport slave (
        input  mem_addr, mem_write_data, mem_write, mem_request,
        output mem_ready, mem_data, busy
    );

endinterface

// File: rtl/dmem_array.sv
// Word storage: synchronous write, combinational read, whole array cleared on rst.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic [XLEN-1:0]  wdata,
    input  logic [IDX_W-1:0] ridx,
    output logic [XLEN-1:0]  rdata
);

    logic [XLEN-1:0] mem [MEM_WORDS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder: one request at a time, fixed LATENCY, single-cycle mem_ready pulse.
// Optional read/write statistics counters are enabled with `define DMEM_RESP_STATS_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 4
) (
    input  logic               clk,
    input  logic               rst,
    dmem_responder_if.slave    bus
`ifdef DMEM_RESP_STATS_EN
    ,
    output logic [31:0]        rd_count,
    output logic [31:0]        wr_count
`endif
);

    localparam int             IDX_W    = $clog2(MEM_WORDS);
    localparam int             CW       = cnt_width(LATENCY);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(LATENCY - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_dec;
    dmem_req_t       req_q, req_in, req_cur;
    logic            pending, resp_entry;
    logic [IDX_W-1:0] idx;
    logic [XLEN-1:0] rd_word, mem_data_q;
    logic            unused_addr_bits;

    assign pending = bus.mem_write | bus.mem_request;

    always_comb begin
        req_in          = '0;
        req_in.addr     = bus.mem_addr;
        req_in.data     = bus.mem_write_data;
        req_in.is_write = bus.mem_write;
    end

    // With LATENCY==1 RESP is entered on the accept edge, before req_q holds the request.
    assign req_cur    = (state_q == IDLE) ? req_in : req_q;
    assign idx        = req_cur.addr[IDX_W+1:2];
    assign cnt_dec    = cnt_q - CW'(1);
    assign resp_entry = (state_d == RESP) && (state_q != RESP);

    // Byte-offset and above-index address bits alias onto the array.
    assign unused_addr_bits = ^{req_cur.addr[XLEN-1:IDX_W+2], req_cur.addr[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pending) state_d = (LATENCY == 1) ? RESP : BUSY;
            BUSY:    if (cnt_dec == '0) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_ready = (state_q == RESP);
        bus.busy      = (state_q != IDLE);
        bus.mem_data  = mem_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            req_q      <= '0;
            mem_data_q <= '0;
        end else begin
            if (state_q == IDLE && pending) begin
                req_q <= req_in;
                cnt_q <= CNT_LOAD;
            end else if (state_q == BUSY) begin
                cnt_q <= cnt_dec;
            end
            if (resp_entry) begin
                mem_data_q <= req_cur.is_write ? req_cur.data : rd_word;
            end
        end
    end

    dmem_array #(
        .MEM_WORDS (MEM_WORDS),
        .IDX_W     (IDX_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (resp_entry & req_cur.is_write),
        .widx  (idx),
        .wdata (req_cur.data),
        .ridx  (idx),
        .rdata (rd_word)
    );

`ifdef DMEM_RESP_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (resp_entry) begin
            if (req_cur.is_write) begin
                wr_count <= sat_inc(wr_count);
            end else begin
                rd_count <= sat_inc(rd_count);
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: vector table with a response scoreboard plus reset-abort sequences.
module tb_dmem_responder;

    localparam int LAT = 4;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic        noisy;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    logic [31:0] exp_q[$];
    vec_t vecs[11];

`ifdef DMEM_RESP_STATS_EN
    logic [31:0] rd_count, wr_count;
`endif

    dmem_responder_if bus();

    dmem_responder #(
        .MEM_WORDS (1024),
        .LATENCY   (LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus)
`ifdef DMEM_RESP_STATS_EN
        ,
        .rd_count (rd_count),
        .wr_count (wr_count)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic idle_inputs();
        bus.mem_write      = 1'b0;
        bus.mem_request    = 1'b0;
        bus.mem_addr       = '0;
        bus.mem_write_data = '0;
    endtask

    // Drives one request in the first IDLE cycle and watches cycles 1..LAT after the accept edge.
    task automatic run_txn(input string nm, input vec_t v, output int rdy_cyc);
        int   pulses;
        int   rdy_at;
        logic busy_ok;
        @(negedge clk);
        check({nm, "_pre_ready"}, 32'(bus.mem_ready), 32'd0);
        check({nm, "_pre_busy"}, 32'(bus.busy), 32'd0);
        bus.mem_write      = v.wr;
        bus.mem_request    = v.rd;
        bus.mem_addr       = v.addr;
        bus.mem_write_data = v.data;
        exp_q.push_back(v.exp);
        @(posedge clk);
        pulses  = 0;
        rdy_at  = -1;
        rdy_cyc = -1;
        busy_ok = 1'b1;
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk);
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (bus.mem_ready === 1'b1) begin
                pulses++;
                rdy_at  = c;
                rdy_cyc = cyc;
                if (exp_q.size() > 0) check({nm, "_data"}, bus.mem_data, exp_q.pop_front());
                else check({nm, "_unexpected_ready"}, 32'd1, 32'd0);
            end
            if (v.noisy && c < LAT) begin
                bus.mem_request    = 1'b1;
                bus.mem_write      = 1'($urandom_range(0, 1));
                bus.mem_addr       = $urandom;
                bus.mem_write_data = $urandom;
            end else begin
                idle_inputs();
            end
        end
        check({nm, "_pulses"}, 32'(pulses), 32'd1);
        check({nm, "_latency"}, 32'(rdy_at), 32'(LAT));
        check({nm, "_busy"}, 32'(busy_ok), 32'd1);
        if (pulses == 0) exp_q.delete();
    endtask

    initial begin
        int   prev_rdy, cur_rdy;
        bit   seen;
        vec_t v;

        idle_inputs();
        vecs[0]  = '{1'b1, 1'b0, 32'h0000_0014, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF};
        vecs[1]  = '{1'b0, 1'b1, 32'h0000_0014, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h1234_5678, 1'b0, 32'h1234_5678};
        vecs[3]  = '{1'b0, 1'b1, 32'h0000_0040, 32'h0000_0000, 1'b0, 32'h1234_5678};
        vecs[4]  = '{1'b1, 1'b1, 32'h0000_0008, 32'hA5A5_A5A5, 1'b0, 32'hA5A5_A5A5};
        vecs[5]  = '{1'b0, 1'b1, 32'h0000_0008, 32'h0000_0000, 1'b0, 32'hA5A5_A5A5};
        vecs[6]  = '{1'b1, 1'b0, 32'h0000_0020, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D};
        vecs[7]  = '{1'b0, 1'b1, 32'h0000_0020, 32'h0000_0000, 1'b1, 32'hCAFE_F00D};
        vecs[8]  = '{1'b1, 1'b0, 32'h1000_0004, 32'h0000_0007, 1'b0, 32'h0000_0007};
        vecs[9]  = '{1'b0, 1'b1, 32'h0000_0004, 32'h0000_0000, 1'b0, 32'h0000_0007};
        vecs[10] = '{1'b0, 1'b1, 32'h1000_0016, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};

        // Reset state
        #2;
        check("rst_ready", 32'(bus.mem_ready), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_data", bus.mem_data, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        prev_rdy = -1;
        for (int i = 0; i < 11; i++) begin
            run_txn($sformatf("v%0d", i), vecs[i], cur_rdy);
            if (i > 0) check($sformatf("v%0d_spacing", i), 32'(cur_rdy - prev_rdy), 32'(LAT + 1));
            prev_rdy = cur_rdy;
        end
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

`ifdef DMEM_RESP_STATS_EN
        check("wr_count", wr_count, 32'd5);
        check("rd_count", rd_count, 32'd6);
`endif

        // Reset two cycles into a write to word 0
        @(negedge clk);
        bus.mem_write      = 1'b1;
        bus.mem_addr       = 32'h0;
        bus.mem_write_data = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_ready", 32'(bus.mem_ready), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
`ifdef DMEM_RESP_STATS_EN
        check("wr_count_rst", wr_count, 32'd0);
        check("rd_count_rst", rd_count, 32'd0);
`endif
        v = '{1'b0, 1'b1, 32'h0000_0000, 32'h0, 1'b0, 32'h0000_0000};
        run_txn("abort_word0", v, cur_rdy);

        // Reset while mem_ready is high drops it without waiting for a clock
        v = '{1'b1, 1'b0, 32'h0000_0040, 32'h0000_0055, 1'b0, 32'h0000_0055};
        run_txn("pre_resp_abort", v, cur_rdy);
        @(negedge clk);
        bus.mem_request = 1'b1;
        bus.mem_addr    = 32'h40;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        seen = 1'b0;
        for (int c = 0; c < LAT + 2 && !seen; c++) begin
            if (bus.mem_ready === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        check("resp_abort_seen", 32'(seen), 32'd1);
        check("resp_abort_data_before", bus.mem_data, 32'h0000_0055);
        #1 rst = 1'b1;
        #1;
        check("resp_abort_ready", 32'(bus.mem_ready), 32'd0);
        check("resp_abort_data", bus.mem_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
